// File: rtl/debounce_evt_ctrl.sv
// ============================================================================
// Module   : debounce_evt_ctrl
// Brief    : Per-channel synchronizer + debouncer with round-robin edge-event queue.
//            Event path built only when DEBOUNCE_EVT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_evt_ctrl #(
    parameter int NB_CH     = 4,
    parameter int NB_STAGES = 3,
    parameter int CNT_W     = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_en,
    input  logic [CNT_W-1:0]                             cfg_thresh,
    input  logic                                         cfg_ovr_clr,
    input  logic [NB_CH-1:0]                             i_raw,
    output logic [NB_CH-1:0]                             o_level,
    output logic                                         o_evt_valid,
    output logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0] o_evt_ch,
    output logic                                         o_evt_rise,
    input  logic                                         evt_ack,
    output logic                                         o_overrun
);

    localparam int CH_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    logic [NB_CH-1:0] r_sync [NB_STAGES];
    logic [NB_CH-1:0] w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_raw;
            for (int i = 1; i < NB_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[NB_STAGES-1];

    state_t           r_state     [NB_CH];
    state_t           w_state_nxt [NB_CH];
    logic [CNT_W-1:0] r_cnt       [NB_CH];
    logic [CNT_W-1:0] w_cnt_nxt   [NB_CH];
    logic [NB_CH-1:0] r_level;
    logic [NB_CH-1:0] w_level_nxt;
    logic [NB_CH-1:0] w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_level <= '0;
        end else begin
            for (int i = 0; i < NB_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_level <= w_level_nxt;
        end
    end

    // A counter that outgrows a lowered threshold still qualifies instead of wrapping.
    always_comb begin
        w_level_nxt = r_level;
        w_edge      = '0;
        for (int i = 0; i < NB_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (!cfg_en) begin
                w_state_nxt[i] = ST_IDLE;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_s[i] != r_level[i]) begin
                            if (cfg_thresh == '0) begin
                                w_level_nxt[i] = w_s[i];
                                w_edge[i]      = 1'b1;
                            end else begin
                                w_cnt_nxt[i]   = CNT_W'(1);
                                w_state_nxt[i] = ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (w_s[i] == r_level[i]) begin
                            w_cnt_nxt[i]   = '0;
                            w_state_nxt[i] = ST_IDLE;
                        end else if (r_cnt[i] >= cfg_thresh) begin
                            w_level_nxt[i] = w_s[i];
                            w_edge[i]      = 1'b1;
                            w_cnt_nxt[i]   = '0;
                            w_state_nxt[i] = ST_IDLE;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;

`ifdef DEBOUNCE_EVT_EN
    logic [NB_CH-1:0] r_pend;
    logic [NB_CH-1:0] r_pend_rise;
    logic             r_evt_valid;
    logic             r_evt_rise;
    logic             r_overrun;
    logic [CH_W-1:0]  r_evt_ch;
    logic [CH_W-1:0]  r_last;
    logic [CH_W-1:0]  w_win;
    logic [NB_CH-1:0] w_grant;
    logic [NB_CH-1:0] w_take;
    logic             w_found;
    logic             w_load;
    logic             w_ovr_set;

    // Round robin: first pending above the last grant, else lowest pending (wrap).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_grant = '0;
        for (int i = 0; i < NB_CH; i++) begin
            if (!w_found && r_pend[i] && (i > int'(r_last))) begin
                w_found    = 1'b1;
                w_win      = CH_W'(i);
                w_grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NB_CH; i++) begin
            if (!w_found && r_pend[i]) begin
                w_found    = 1'b1;
                w_win      = CH_W'(i);
                w_grant[i] = 1'b1;
            end
        end
        w_load    = (!r_evt_valid || evt_ack) && (|r_pend);
        w_take    = w_grant & {NB_CH{w_load}};
        w_ovr_set = |(w_edge & r_pend & ~w_take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_rise <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
            r_overrun   <= 1'b0;
            r_last      <= CH_W'(NB_CH - 1);
        end else begin
            r_pend      <= (r_pend & ~w_take) | w_edge;
            r_pend_rise <= (r_pend_rise & ~w_edge) | (w_level_nxt & w_edge);
            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_win;
                r_evt_rise  <= r_pend_rise[w_win];
                r_last      <= w_win;
            end else if (evt_ack) begin
                r_evt_valid <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (cfg_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_rise  = r_evt_rise;
    assign o_overrun   = r_overrun;
`else
    logic w_unused;
    assign w_unused    = ^{w_edge, evt_ack, cfg_ovr_clr};
    assign o_evt_valid = 1'b0;
    assign o_evt_ch    = '0;
    assign o_evt_rise  = 1'b0;
    assign o_overrun   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_evt_ctrl.sv
// ============================================================================
// Module   : tb_debounce_evt_ctrl
// Brief    : Directed self-checking bench for debounce_evt_ctrl (table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_evt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic [7:0] cfg_thresh;
    logic       cfg_ovr_clr;
    logic [3:0] i_raw;
    logic [3:0] o_level;
    logic       o_evt_valid;
    logic [1:0] o_evt_ch;
    logic       o_evt_rise;
    logic       evt_ack;
    logic       o_overrun;

    int n_pass = 0;
    int n_tot  = 0;

    debounce_evt_ctrl #(.NB_CH(4), .NB_STAGES(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_thresh (cfg_thresh),
        .cfg_ovr_clr(cfg_ovr_clr),
        .i_raw      (i_raw),
        .o_level    (o_level),
        .o_evt_valid(o_evt_valid),
        .o_evt_ch   (o_evt_ch),
        .o_evt_rise (o_evt_rise),
        .evt_ack    (evt_ack),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic       en;
        logic [7:0] th;
        int         ncyc;
        logic [3:0] exp_level;
    } vec_t;

    vec_t vecs [21];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        i_raw       = '0;
        evt_ack     = 1'b0;
        cfg_ovr_clr = 1'b0;
        cfg_en      = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Latency with thresh T is 3+T+1; a pulse must last T+1 cycles to qualify.
        vecs[0]  = '{4'b0001, 1'b1, 8'd4, 7,  4'b0000};
        vecs[1]  = '{4'b0001, 1'b1, 8'd4, 1,  4'b0001};
        vecs[2]  = '{4'b0011, 1'b1, 8'd4, 7,  4'b0001};
        vecs[3]  = '{4'b0011, 1'b1, 8'd4, 1,  4'b0011};
        vecs[4]  = '{4'b0111, 1'b1, 8'd4, 4,  4'b0011};
        vecs[5]  = '{4'b0011, 1'b1, 8'd4, 12, 4'b0011};
        vecs[6]  = '{4'b0111, 1'b1, 8'd4, 5,  4'b0011};
        vecs[7]  = '{4'b0011, 1'b1, 8'd4, 3,  4'b0111};
        vecs[8]  = '{4'b0011, 1'b1, 8'd4, 4,  4'b0111};
        vecs[9]  = '{4'b0011, 1'b1, 8'd4, 1,  4'b0011};
        vecs[10] = '{4'b1011, 1'b1, 8'd0, 3,  4'b0011};
        vecs[11] = '{4'b1011, 1'b1, 8'd0, 1,  4'b1011};
        vecs[12] = '{4'b1010, 1'b1, 8'd1, 4,  4'b1011};
        vecs[13] = '{4'b1010, 1'b1, 8'd1, 1,  4'b1010};
        vecs[14] = '{4'b0000, 1'b0, 8'd4, 20, 4'b1010};
        vecs[15] = '{4'b0000, 1'b1, 8'd4, 4,  4'b1010};
        vecs[16] = '{4'b0000, 1'b1, 8'd4, 1,  4'b0000};
        vecs[17] = '{4'b0100, 1'b1, 8'd4, 6,  4'b0000};
        vecs[18] = '{4'b0100, 1'b0, 8'd4, 3,  4'b0000};
        vecs[19] = '{4'b0100, 1'b1, 8'd4, 4,  4'b0000};
        vecs[20] = '{4'b0100, 1'b1, 8'd4, 1,  4'b0100};

        cfg_thresh = 8'd4;
        do_reset();
        check("reset_level",   32'(o_level),     32'h0);
        check("reset_valid",   32'(o_evt_valid), 32'h0);
        check("reset_overrun", 32'(o_overrun),   32'h0);

        evt_ack = 1'b1;
        for (int v = 0; v < 21; v++) begin
            i_raw      = vecs[v].raw;
            cfg_en     = vecs[v].en;
            cfg_thresh = vecs[v].th;
            tick(vecs[v].ncyc);
            check($sformatf("vec%0d_level", v), 32'(o_level), 32'(vecs[v].exp_level));
`ifndef DEBOUNCE_EVT_EN
            check($sformatf("vec%0d_valid_off", v), 32'(o_evt_valid), 32'h0);
            check($sformatf("vec%0d_ovr_off", v),   32'(o_overrun),   32'h0);
`endif
        end

`ifdef DEBOUNCE_EVT_EN
        // Three channels qualify together; ack held high drains them back-to-back.
        cfg_thresh = 8'd0;
        do_reset();
        evt_ack = 1'b1;
        i_raw   = 4'b1101;
        tick(5);
        check("rr_level", 32'(o_level), 32'hd);
        check("rr_ev0",   32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd0, 1'b1}));
        tick(1);
        check("rr_ev1",   32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd2, 1'b1}));
        tick(1);
        check("rr_ev2",   32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd3, 1'b1}));
        tick(1);
        check("rr_drain", 32'(o_evt_valid), 32'h0);

        // Overrun: ch0 occupies output unacked, ch1 rises then falls behind it.
        cfg_thresh = 8'd2;
        do_reset();
        i_raw = 4'b0001;
        tick(7);
        check("ovr_ev0",   32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd0, 1'b1}));
        i_raw = 4'b0011;
        tick(6);
        check("ovr_none",  32'(o_overrun), 32'h0);
        check("ovr_hold",  32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd0, 1'b1}));
        i_raw = 4'b0001;
        tick(6);
        check("ovr_set",   32'(o_overrun), 32'h1);
        evt_ack = 1'b1;
        tick(1);
        check("ovr_ev1",   32'({o_evt_valid, o_evt_ch, o_evt_rise}), 32'({1'b1, 2'd1, 1'b0}));
        tick(1);
        check("ovr_empty", 32'(o_evt_valid), 32'h0);
        check("ovr_stick", 32'(o_overrun),   32'h1);
        evt_ack     = 1'b0;
        cfg_ovr_clr = 1'b1;
        tick(1);
        cfg_ovr_clr = 1'b0;
        check("ovr_clr",   32'(o_overrun), 32'h0);
`endif

        // Asynchronous reset while ch2 is debouncing and an event is held.
        cfg_thresh = 8'd4;
        do_reset();
        i_raw = 4'b0001;
        tick(9);
        check("rst_pre_level", 32'(o_level), 32'h1);
`ifdef DEBOUNCE_EVT_EN
        check("rst_pre_valid", 32'(o_evt_valid), 32'h1);
`endif
        i_raw = 4'b0101;
        tick(5);
        #2;
        rst   = 1'b1;
        i_raw = 4'b0000;
        #1;
        check("rst_async_level", 32'(o_level), 32'h0);
        check("rst_async_evt",   32'({o_evt_valid, o_evt_ch, o_evt_rise, o_overrun}), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("rst_post_level", 32'(o_level),     32'h0);
        check("rst_post_valid", 32'(o_evt_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_evt_ctrl.md
DEBOUNCE_EVT_CTRL -- requirements
Module: debounce_evt_ctrl

Interface
REQ-001 SHALL have parameter NB_CH, default 4, number of input channels (1..16).
REQ-002 SHALL have parameter NB_STAGES, default 3, synchronizer depth per channel (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, debounce counter width.
REQ-004 SHALL have port clk  input  1  clock (rising edge).
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_en  input  1  debounce enable.
REQ-007 SHALL have port cfg_thresh  input  CNT_W  stable-cycle threshold.
REQ-008 SHALL have port cfg_ovr_clr  input  1  pulse, clears o_overrun.
REQ-009 SHALL have port i_raw  input  NB_CH  asynchronous raw inputs.
REQ-010 SHALL have port o_level  output  NB_CH  debounced levels.
REQ-011 SHALL have port o_evt_valid  output  1  event available.
REQ-012 SHALL have port o_evt_ch  output  $clog2(NB_CH) (min 1)  event channel index.
REQ-013 SHALL have port o_evt_rise  output  1  1=rising, 0=falling edge.
REQ-014 SHALL have port evt_ack  input  1  event consumed when high with o_evt_valid.
REQ-015 SHALL have port o_overrun  output  1  sticky, an edge overwrote an undelivered event.

Function
REQ-016 Each channel SHALL pass i_raw through NB_STAGES flops (reset 0); last stage is sync value S.
REQ-017 Each channel SHALL run FSM IDLE/CHECK with counter C (CNT_W bits) and level L (= o_level bit).
REQ-018 IDLE, S!=L, cfg_thresh==0: L<=S, qualified edge, stay IDLE.
REQ-019 IDLE, S!=L, cfg_thresh!=0: C<=1, go CHECK.
REQ-020 CHECK, S==L: C<=0, go IDLE, no edge (glitch rejected).
REQ-021 CHECK, S!=L, C==cfg_thresh: L<=S, C<=0, go IDLE, qualified edge.
REQ-022 CHECK, S!=L, C<cfg_thresh: C<=C+1; C never wraps.
REQ-023 Latency i_raw change to o_level change SHALL be NB_STAGES+cfg_thresh+1 cycles for a stable input.
REQ-024 cfg_en=0: all FSMs forced IDLE, C=0, L frozen; sync stages, pending flags and event delivery continue.
REQ-025 Qualified edge SHALL set pending[ch] and store direction (L new value) in pend_rise[ch].
REQ-026 Edge on channel with pending[ch] already set and not being loaded this cycle SHALL overwrite direction and set o_overrun.
REQ-027 Output register loads when (!o_evt_valid | evt_ack) and any pending: round-robin winner, search starts at last granted index+1, wrapping.
REQ-028 Load SHALL clear winner's pending bit same cycle; a coincident new edge on winner keeps pending set with new direction, no overrun.
REQ-029 o_evt_valid/o_evt_ch/o_evt_rise SHALL stay stable while valid and !evt_ack; ack with nothing pending drops valid next cycle.
REQ-030 Back-to-back: ack with pending present SHALL present next event next cycle, no bubble.
REQ-031 cfg_ovr_clr SHALL clear o_overrun; a simultaneous overrun event takes priority (stays set).

Reset
REQ-032 rst high SHALL asynchronously clear sync flops, L, C, FSMs (IDLE), pending, pend_rise, o_evt_valid, o_evt_ch, o_evt_rise, o_overrun, round-robin pointer (last granted = NB_CH-1).
REQ-033 Reset mid-debounce or mid-handshake SHALL discard all in-flight state; no event after release until a new qualified edge.

Configuration
REQ-034 Macro DEBOUNCE_EVT_EN defined: pending flags, arbiter, event outputs, overrun logic as above.
REQ-035 Macro DEBOUNCE_EVT_EN undefined: ports retained; o_evt_valid, o_evt_ch, o_evt_rise, o_overrun tied 0; evt_ack, cfg_ovr_clr ignored; o_level behaviour unchanged.

Verification
REQ-036 NB_STAGES=3, thresh=4, ch0 0->1 held -> o_level[0] rises 8 cycles later; event ch0 rise=1.
REQ-037 thresh=4, ch1 pulse high 3 cycles -> o_level unchanged, no event.
REQ-038 ch0,ch2,ch3 qualify same cycle, evt_ack tied 1 -> events ch0,ch2,ch3 on consecutive cycles.
REQ-039 evt_ack=0, ch1 rises then falls (thresh=2) -> o_overrun=1, pending ch1 rise=0; cfg_ovr_clr -> o_overrun=0.
REQ-040 rst asserted while ch2 in CHECK with event valid -> all outputs 0 immediately; no event after release with inputs static 0.
REQ-041 DEBOUNCE_EVT_EN undefined, ch0 toggles -> o_level tracks, o_evt_valid stays 0.
